// File: rtl/systolic_job_ctrl_pkg.sv
// Shared definitions for the 3x3 systolic job sequencer: geometry,
// FSM state codes and the row-major matrix index helper.
package systolic_job_ctrl_pkg;

    localparam int N          = 3;
    localparam int ELEMS      = N * N;
    localparam int FEED_STEPS = 2 * N - 1;
    localparam int IDX_W      = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_FEED    = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;

    function automatic logic [IDX_W-1:0] mat_idx(input int row, input int col);
        return IDX_W'(row * N + col);
    endfunction

endpackage

// File: rtl/systolic_job_ctrl_if.sv
// Host register port plus array-facing streams of the job sequencer.
// master = host/array side, slave = the sequencer.
interface systolic_job_ctrl_if
    import systolic_job_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 64
) ();

    logic                 wr_en;
    logic                 wr_sel;
    logic [IDX_W-1:0]     wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 res_valid;
    logic [IDX_W-1:0]     rd_addr;
    logic [RW-1:0]        rd_data;
    logic                 arr_clr;
    logic [DW-1:0]        arr_a, arr_b, arr_c;
    logic [DW-1:0]        arr_d, arr_e, arr_f;
    logic [ELEMS*RW-1:0]  arr_out;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr, arr_out,
        input  busy, done, res_valid, rd_data, arr_clr,
        input  arr_a, arr_b, arr_c, arr_d, arr_e, arr_f
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr, arr_out,
        output busy, done, res_valid, rd_data, arr_clr,
        output arr_a, arr_b, arr_c, arr_d, arr_e, arr_f
    );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Produces the three diagonally skewed stream values for feed step t:
// lane r carries mat[r][t-r] while that column exists, else zero.
module systolic_skew_feeder
    import systolic_job_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]                step,
    input  logic [ELEMS-1:0][DW-1:0]  mat,
    output logic [N-1:0][DW-1:0]      lanes
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        lanes = '0;
        for (int r = 0; r < N; r++) begin
            if (int'(step) >= r && int'(step) - r < N) begin
                lanes[r] = mat[mat_idx(r, int'(step) - r)];
            end
        end
    end

endmodule

// File: rtl/systolic_job_ctrl.sv
// Job sequencer for the 3x3 output-stationary systolic multiplier: holds
// operands A/B, streams them skewed into the array and captures C.
module systolic_job_ctrl
    import systolic_job_ctrl_pkg::*;
#(
    parameter int DW           = 32,
    parameter int RW           = 64,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    systolic_job_ctrl_if.slave  bus
);

    localparam int CNT_W = (DRAIN_CYCLES > 8) ? $clog2(DRAIN_CYCLES) : 3;

    logic [2:0]                state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [ELEMS-1:0][DW-1:0]  a_mat, b_mat, b_t;
    logic [ELEMS-1:0][RW-1:0]  c_mem;
    logic [N-1:0][DW-1:0]      row_lanes, col_lanes;
    logic [N-1:0][DW-1:0]      row_q, col_q;
    logic                      done_q, res_valid_q;
    logic                      feed_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_FEED;
                cnt_nxt   = '0;
            end
            ST_FEED: begin
                if (cnt == CNT_W'(FEED_STEPS - 1)) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt = ST_CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Columns are fed from B transposed so one feeder serves both sides.
    always_comb begin
        b_t = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                b_t[mat_idx(r, c)] = b_mat[mat_idx(c, r)];
            end
        end
    end

    // Streams are registered, so the feeders look at the step being entered.
    assign feed_nxt = (state_nxt == ST_FEED);

    systolic_skew_feeder #(.DW(DW)) u_row_feeder (
        .step  (cnt_nxt[2:0]),
        .mat   (a_mat),
        .lanes (row_lanes)
    );

    systolic_skew_feeder #(.DW(DW)) u_col_feeder (
        .step  (cnt_nxt[2:0]),
        .mat   (b_t),
        .lanes (col_lanes)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the operand and result stores are small register files, and they
    // are reset because a reset must leave C reading back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            a_mat       <= '0;
            b_mat       <= '0;
            c_mem       <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= (state == ST_CAPTURE);
            row_q  <= feed_nxt ? row_lanes : '0;
            col_q  <= feed_nxt ? col_lanes : '0;

            if (state == ST_CAPTURE) begin
                res_valid_q <= 1'b1;
            end else if (state == ST_IDLE && bus.start) begin
                res_valid_q <= 1'b0;
            end

            // A and B are frozen for the whole job; a same-cycle start sees the write.
            if (state == ST_IDLE && bus.wr_en && bus.wr_addr < IDX_W'(ELEMS)) begin
                if (bus.wr_sel) begin
                    b_mat[bus.wr_addr] <= bus.wr_data;
                end else begin
                    a_mat[bus.wr_addr] <= bus.wr_data;
                end
            end

            if (state == ST_CAPTURE) begin
                for (int k = 0; k < ELEMS; k++) begin
                    c_mem[k] <= bus.arr_out[k*RW +: RW];
                end
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.rd_addr < IDX_W'(ELEMS)) begin
            bus.rd_data = c_mem[bus.rd_addr];
        end
    end

    // The array is held in reset whenever our own reset is asserted.
    assign bus.arr_clr   = rst || (state == ST_CLEAR);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.arr_a     = row_q[0];
    assign bus.arr_b     = row_q[1];
    assign bus.arr_c     = row_q[2];
    assign bus.arr_d     = col_q[0];
    assign bus.arr_e     = col_q[1];
    assign bus.arr_f     = col_q[2];

endmodule

// File: tb/tb_systolic_job_ctrl.sv
// Scoreboard bench for systolic_job_ctrl: an output-stationary array model
// supplies arr_out, expected C comes from a plain matrix product.
module tb_systolic_job_ctrl;
    import systolic_job_ctrl_pkg::*;

    localparam int DW       = 32;
    localparam int RW       = 64;
    localparam int DC       = 4;
    localparam int DONE_OFS = 7 + DC;

    typedef struct packed {
        logic [8:0][63:0] c;
        logic [31:0]      done_edge;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    systolic_job_ctrl_if #(.DW(DW), .RW(RW)) bus ();

    systolic_job_ctrl #(.DW(DW), .RW(RW), .DRAIN_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    job_t             sb[$];
    logic [31:0]      m_a[9];
    logic [31:0]      m_b[9];
    bit               m_act = 1'b0;
    int               m_t0  = 0;
    bit               m_rv  = 1'b0;
    logic [8:0][63:0] m_c   = '0;
    bit               chk_rd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- array environment model ----------------
    logic [63:0] acc[3][3];
    logic [31:0] hreg[3][3];
    logic [31:0] vreg[3][3];

    always @(posedge clk) begin
        logic [31:0] ain, bin;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (bus.arr_clr) begin
                    acc[i][j]  <= '0;
                    hreg[i][j] <= '0;
                    vreg[i][j] <= '0;
                end else begin
                    if (j == 0) ain = (i == 0) ? bus.arr_a : (i == 1) ? bus.arr_b : bus.arr_c;
                    else        ain = hreg[i][j-1];
                    if (i == 0) bin = (j == 0) ? bus.arr_d : (j == 1) ? bus.arr_e : bus.arr_f;
                    else        bin = vreg[i-1][j];
                    acc[i][j]  <= acc[i][j] + 64'(ain) * 64'(bin);
                    hreg[i][j] <= ain;
                    vreg[i][j] <= bin;
                end
            end
        end
    end

    always_comb begin
        logic [575:0] t;
        t = '0;
        for (int k = 0; k < 9; k++) t[k*64 +: 64] = acc[k/3][k%3];
        bus.arr_out = t;
    end

    // ---------------- reference model ----------------
    function automatic logic [8:0][63:0] ref_mul();
        logic [8:0][63:0] r;
        logic [63:0] s;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int k = 0; k < 3; k++) s += 64'(m_a[i*3+k]) * 64'(m_b[k*3+j]);
                r[i*3+j] = s;
            end
        end
        return r;
    endfunction

    // Applies the job rules for the edge just taken, using the inputs held across it.
    task automatic model_edge();
        int   e = cyc;
        bit   idle;
        job_t j;
        if (rst) begin
            m_act = 1'b0;
            m_rv  = 1'b0;
            for (int k = 0; k < 9; k++) begin
                m_a[k] = '0;
                m_b[k] = '0;
            end
            sb.delete();
            return;
        end
        idle = !m_act || (e > m_t0 + DONE_OFS);
        if (m_act && e == m_t0 + DONE_OFS) m_rv = 1'b1;
        if (idle && bus.wr_en && bus.wr_addr < 4'd9) begin
            if (bus.wr_sel) m_b[bus.wr_addr] = bus.wr_data;
            else            m_a[bus.wr_addr] = bus.wr_data;
        end
        if (idle && bus.start) begin
            m_act       = 1'b1;
            m_t0        = e;
            m_rv        = 1'b0;
            j.c         = ref_mul();
            j.done_edge = 32'(e + DONE_OFS);
            sb.push_back(j);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic rd_all(input string tag);
        for (int k = 0; k < 9; k++) begin
            bus.rd_addr = 4'(k);
            #1;
            check($sformatf("%s_c%0d", tag, k), bus.rd_data, m_c[k]);
        end
        bus.rd_addr = 4'd13;
        #1;
        check($sformatf("%s_addr13", tag), bus.rd_data, 64'd0);
    endtask

    initial begin
        job_t j;
        bit   exp_busy;
        bus.rd_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) m_c = '0;
            exp_busy = m_act && (cyc < m_t0 + DONE_OFS);
            check("busy", 64'(bus.busy), 64'(exp_busy));
            check("res_valid", 64'(bus.res_valid), 64'(m_rv));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    j = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(j.done_edge));
                    m_c = j.c;
                    rd_all("rd_done");
                end
            end else begin
                if (sb.size() > 0 && cyc > int'(sb[0].done_edge)) begin
                    checks++;
                    failures++;
                    $display("FAIL done_timeout actual=0 expected=1 (cycle %0d)", cyc);
                    void'(sb.pop_front());
                end
                if (chk_rd) begin
                    chk_rd = 1'b0;
                    rd_all("rd_idle");
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        @(negedge clk);
    endtask

    task automatic wr(input bit sel, input int addr, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 4'(addr);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic load_rand();
        for (int k = 0; k < 9; k++) wr(1'b0, k, $urandom);
        for (int k = 0; k < 9; k++) wr(1'b1, k, $urandom);
    endtask

    task automatic start_job();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_act && cyc < m_t0 + DONE_OFS + 1 && n < 100) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic check_streams(input string tag, input logic [5:0][31:0] exp);
        check({tag, "_a"}, 64'(bus.arr_a), 64'(exp[0]));
        check({tag, "_b"}, 64'(bus.arr_b), 64'(exp[1]));
        check({tag, "_c"}, 64'(bus.arr_c), 64'(exp[2]));
        check({tag, "_d"}, 64'(bus.arr_d), 64'(exp[3]));
        check({tag, "_e"}, 64'(bus.arr_e), 64'(exp[4]));
        check({tag, "_f"}, 64'(bus.arr_f), 64'(exp[5]));
    endtask

    initial begin
        int t0, n;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_arr_clr", 64'(bus.arr_clr), 64'd1);
        check_streams("rst_stream", '0);
        rst = 1'b0;
        tick();
        check("idle_arr_clr", 64'(bus.arr_clr), 64'd0);

        // Identity job with skew checks
        for (int k = 0; k < 9; k++) wr(1'b0, k, 32'(k + 1));
        for (int k = 0; k < 9; k++) wr(1'b1, k, (k % 4 == 0) ? 32'd1 : 32'd0);
        start_job();
        t0 = m_t0;
        check("clear_arr_clr", 64'(bus.arr_clr), 64'd1);
        check_streams("clear_stream", '0);
        while (cyc < t0 + 3) tick();
        check("feed_arr_clr", 64'(bus.arr_clr), 64'd0);
        check_streams("skew_t2", {32'd0, 32'd1, 32'd0, 32'd7, 32'd5, 32'd3});
        while (cyc < t0 + 5) tick();
        check_streams("skew_t4", {32'd1, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0});
        tick();
        check_streams("drain_stream", '0);
        wait_idle();

        // Overflow: each C = 3*(2^32-1)^2 mod 2^64
        for (int k = 0; k < 9; k++) wr(1'b0, k, 32'hFFFF_FFFF);
        for (int k = 0; k < 9; k++) wr(1'b1, k, 32'hFFFF_FFFF);
        start_job();
        wait_idle();
        chk_rd = 1'b1;
        tick();
        check("ovf_model", ref_mul()[4], 64'hFFFF_FFFA_0000_0003);

        // Busy protection: write and start during FEED are ignored
        load_rand();
        start_job();
        t0 = m_t0;
        while (cyc < t0 + 3) tick();
        bus.start = 1'b1;
        wr(1'b0, 0, 32'd99);
        bus.start = 1'b0;
        wait_idle();

        // Back-to-back: start held across the done cycle
        load_rand();
        bus.start = 1'b1;
        tick();
        t0 = m_t0;
        while (cyc < t0 + DONE_OFS + 1) tick();
        bus.start = 1'b0;
        check("b2b_busy", 64'(bus.busy), 64'd1);
        check("b2b_res_valid", 64'(bus.res_valid), 64'd0);
        wait_idle();

        // Reset in the middle of DRAIN
        load_rand();
        start_job();
        t0 = m_t0;
        while (cyc < t0 + 7) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_arr_clr", 64'(bus.arr_clr), 64'd1);
        tick();
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        chk_rd = 1'b1;
        for (int k = 0; k < 16; k++) tick();

        // Randomised jobs: stray/invalid writes, same-cycle write+start, starts while busy
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 10; w++) wr(1'($urandom_range(1)), int'($urandom_range(15)), $urandom);
            bus.wr_en   = 1'($urandom_range(1));
            bus.wr_sel  = 1'($urandom_range(1));
            bus.wr_addr = 4'($urandom_range(8));
            bus.wr_data = $urandom;
            start_job();
            bus.wr_en = 1'b0;
            n = int'($urandom_range(DONE_OFS + 2));
            for (int k = 0; k < n; k++) begin
                bus.start = 1'($urandom_range(1));
                bus.wr_en = 1'($urandom_range(1));
                bus.wr_addr = 4'($urandom_range(15));
                bus.wr_data = $urandom;
                tick();
            end
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            wait_idle();
        end

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
